matmul_host_ctrl: RTL and testbench
===================================

MATMUL_HOST_CTRL -- requirements
Module: matmul_host_ctrl

Interface
REQ-001 Parameters SHALL be: DWIDTH, 16, element width; AWIDTH, 7, memory address width; MAT_MUL_SIZE, 16, elements per row; NUM_ROWS, 16, rows per matrix; RD_LAT, 3, cycles from addr_pi to valid data_from_out_mat; FIFO_DEPTH, 4, result buffer entries.
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 Ports SHALL be:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- go  in  1  single-cycle job start request
- busy  out  1  high from accepted go until job_done
- job_done  out  1  one-cycle pulse after the last result row is handed off
- s_valid / s_ready / s_data  in / out / in  1 / 1 / MAT_MUL_SIZE*DWIDTH  input row stream, A rows then B rows
- m_valid / m_ready / m_data  out / in / out  1 / 1 / MAT_MUL_SIZE*DWIDTH  result row stream, C rows
- enable_writing_to_mem, enable_reading_from_mem  out  1  accelerator address-mux selects
- addr_pi  out  AWIDTH  accelerator host address
- data_pi  out  MAT_MUL_SIZE*DWIDTH  accelerator write data
- we_a, we_b, we_c  out  1  accelerator write enables
- start_mat_mul  out  1  accelerator run level
- done_mat_mul  in  1  accelerator completion
- data_from_out_mat  in  MAT_MUL_SIZE*DWIDTH  accelerator C read data

Function
REQ-004 FSM states SHALL be IDLE, LOAD_A, LOAD_B, FLUSH, RUN, READ, FINISH.
REQ-005 IDLE: go=1 -> LOAD_A with busy=1; go in any other state SHALL be ignored.
REQ-006 LOAD_A/LOAD_B: s_ready=1, enable_writing_to_mem=1; each handshake (s_valid&s_ready) SHALL drive addr_pi=row index (0..NUM_ROWS-1) in that cycle.
REQ-007 Row data and write enable SHALL be delayed exactly 2 cycles after the handshake: data_pi=captured s_data, with we_a (LOAD_A rows) or we_b (LOAD_B rows) high for 1 cycle; addr_pi and the write enable are never driven in the same cycle.
REQ-008 After handshake NUM_ROWS-1: LOAD_A -> LOAD_B with the row index reset to 0; LOAD_B -> FLUSH.
REQ-009 FLUSH SHALL last 2 cycles with enable_writing_to_mem=1 and s_ready=0 so the final B write lands, then -> RUN.
REQ-010 RUN: start_mat_mul=1 and we_c=1 every cycle; done_mat_mul=1 -> READ, with start_mat_mul and we_c low from the next cycle; done_mat_mul outside RUN SHALL be ignored.
REQ-011 READ: enable_reading_from_mem=1; read address r SHALL be issued on addr_pi only when FIFO occupancy + in-flight reads < FIFO_DEPTH; addresses 0..NUM_ROWS-1 are issued in order, one per cycle at most.
REQ-012 data_from_out_mat SHALL be captured into the FIFO exactly RD_LAT cycles after its address was issued (tracked by an RD_LAT-deep valid shift register); captures are never dropped.
REQ-013 m_valid=FIFO non-empty, m_data=FIFO head, pop on m_valid&m_ready; a simultaneous push and pop SHALL leave occupancy unchanged.
REQ-014 After NUM_ROWS addresses are issued, all captures are complete and the FIFO is empty: -> FINISH; FINISH pulses job_done for 1 cycle, clears busy, then -> IDLE.
REQ-015 Outputs not named as active in a state SHALL be 0; addr_pi and data_pi SHALL be 0 when their strobes are inactive.

Reset
REQ-016 While reset=1 at a clock edge: state=IDLE, all outputs 0 (busy, job_done, s_ready, m_valid, write/read enables, we_*, start_mat_mul, addr_pi, data_pi), FIFO emptied, delay and in-flight pipes cleared, row counters 0.
REQ-017 Reset mid-job SHALL abandon the job with no further memory writes; in-flight reads SHALL be discarded.

Verification
REQ-018 Load path: go, 32 back-to-back rows with value k in row k -> addr_pi=k in handshake cycle n, we_a (rows 0-15) or we_b (rows 16-31) with data_pi=k at cycle n+2; 16 we_a and 16 we_b pulses total.
REQ-019 Stalled input: s_valid low for 5 cycles mid-A -> no spurious we_a; row index continues without skipping.
REQ-020 Run: done_mat_mul asserted 40 cycles into RUN -> start_mat_mul and we_c high for exactly 40 cycles, low afterwards, READ entered.
REQ-021 Backpressure: m_ready=0 during READ -> at most 4 reads outstanding; release -> 16 rows emitted in order 0..15, matching data_from_out_mat returned 3 cycles after each address.
REQ-022 Reset mid-LOAD_B and mid-READ -> all outputs 0 next cycle, m_valid=0; a new go then completes a full job normally.
REQ-023 go while busy and done_mat_mul during LOAD -> no state change; job_done pulses exactly once per job.

Source files
------------

// File: rtl/matmul_host_ctrl.sv
// Host-side controller for a matrix-multiply accelerator: loads A/B rows into
// accelerator memory, runs it, then streams C rows back out through a small FIFO.
module matmul_host_ctrl #(
    parameter int DWIDTH       = 16,
    parameter int AWIDTH       = 7,
    parameter int MAT_MUL_SIZE = 16,
    parameter int NUM_ROWS     = 16,
    parameter int RD_LAT       = 3,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             go,
    output logic                             busy,
    output logic                             job_done,
    input  logic                             s_valid,
    output logic                             s_ready,
    input  logic [MAT_MUL_SIZE*DWIDTH-1:0]   s_data,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic [MAT_MUL_SIZE*DWIDTH-1:0]   m_data,
    output logic                             enable_writing_to_mem,
    output logic                             enable_reading_from_mem,
    output logic [AWIDTH-1:0]                addr_pi,
    output logic [MAT_MUL_SIZE*DWIDTH-1:0]   data_pi,
    output logic                             we_a,
    output logic                             we_b,
    output logic                             we_c,
    output logic                             start_mat_mul,
    input  logic                             done_mat_mul,
    input  logic [MAT_MUL_SIZE*DWIDTH-1:0]   data_from_out_mat
);
    localparam int RW = MAT_MUL_SIZE * DWIDTH;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [AWIDTH-1:0] LAST_ROW  = AWIDTH'(NUM_ROWS - 1);
    localparam logic [AWIDTH-1:0] ALL_ROWS  = AWIDTH'(NUM_ROWS);
    localparam logic [PW-1:0]     LAST_SLOT = PW'(FIFO_DEPTH - 1);

    typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, FLUSH, RUN, READ, FINISH} state_t;
    state_t state, state_nxt;

    logic [AWIDTH-1:0] row_idx;
    logic [AWIDTH-1:0] rd_addr;
    logic              flush_cnt;
    logic [1:0]        wp_vld;
    logic [1:0]        wp_b;
    logic [RW-1:0]     wp_data [2];
    logic [RD_LAT-1:0] rd_pipe;
    logic [RW-1:0]     fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     fifo_cnt;
    logic              load_hs, rd_issue, rd_capture, fifo_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_SLOT) ? '0 : p + 1'b1;
    endfunction

    // Issue gating counts in-flight reads so a capture always has a free slot.
    always_comb begin
        load_hs  = 1'b0;
        rd_issue = 1'b0;
        if ((state == LOAD_A || state == LOAD_B) && s_valid)
            load_hs = 1'b1;
        if (state == READ && rd_addr != ALL_ROWS &&
            (int'(fifo_cnt) + $countones(rd_pipe)) < FIFO_DEPTH)
            rd_issue = 1'b1;
    end

    assign rd_capture = rd_pipe[RD_LAT-1];
    assign fifo_pop   = (fifo_cnt != '0) && m_ready;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (go) state_nxt = LOAD_A;
            LOAD_A:  if (load_hs && row_idx == LAST_ROW) state_nxt = LOAD_B;
            LOAD_B:  if (load_hs && row_idx == LAST_ROW) state_nxt = FLUSH;
            FLUSH:   if (flush_cnt) state_nxt = RUN;
            RUN:     if (done_mat_mul) state_nxt = READ;
            READ:    if (rd_addr == ALL_ROWS && rd_pipe == '0 && fifo_cnt == '0)
                         state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy                    = (state != IDLE) && (state != FINISH);
        job_done                = (state == FINISH);
        s_ready                 = 1'b0;
        enable_writing_to_mem   = 1'b0;
        enable_reading_from_mem = 1'b0;
        start_mat_mul           = 1'b0;
        we_c                    = 1'b0;
        addr_pi                 = '0;
        case (state)
            LOAD_A, LOAD_B: begin
                s_ready               = 1'b1;
                enable_writing_to_mem = 1'b1;
                if (load_hs) addr_pi = row_idx;
            end
            FLUSH: enable_writing_to_mem = 1'b1;
            RUN: begin
                start_mat_mul = 1'b1;
                we_c          = 1'b1;
            end
            READ: begin
                enable_reading_from_mem = 1'b1;
                if (rd_issue) addr_pi = rd_addr;
            end
            default: ;
        endcase
        we_a    = wp_vld[1] & ~wp_b[1];
        we_b    = wp_vld[1] &  wp_b[1];
        data_pi = wp_vld[1] ? wp_data[1] : '0;
        m_valid = (fifo_cnt != '0);
        m_data  = m_valid ? fifo_mem[rd_ptr] : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            row_idx   <= '0;
            rd_addr   <= '0;
            flush_cnt <= 1'b0;
            wp_vld    <= '0;
            wp_b      <= '0;
            rd_pipe   <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_cnt  <= '0;
        end else begin
            if (load_hs) row_idx <= (row_idx == LAST_ROW) ? '0 : row_idx + 1'b1;
            flush_cnt <= (state == FLUSH) ? ~flush_cnt : 1'b0;
            wp_vld    <= {wp_vld[0], load_hs};
            wp_b      <= {wp_b[0], state == LOAD_B};
            if (rd_issue)           rd_addr <= rd_addr + 1'b1;
            else if (state != READ) rd_addr <= '0;
            rd_pipe <= (rd_pipe << 1) | RD_LAT'(rd_issue);
            if (rd_capture) wr_ptr <= ptr_inc(wr_ptr);
            if (fifo_pop)   rd_ptr <= ptr_inc(rd_ptr);
            case ({rd_capture, fifo_pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        wp_data[0] <= s_data;
        wp_data[1] <= wp_data[0];
        if (rd_capture) fifo_mem[wr_ptr] <= data_from_out_mat;
    end
endmodule

// File: tb/tb_matmul_host_ctrl.sv
// Self-checking bench for matmul_host_ctrl with a fixed-latency accelerator read model.
module tb_matmul_host_ctrl;
    localparam int DW = 16, AW = 7, MS = 16, NR = 16, RL = 3, FD = 4;
    localparam int RW = MS * DW;

    logic clk = 1'b0, reset = 1'b1, go = 1'b0, s_valid = 1'b0, m_ready = 1'b0, done_mat_mul = 1'b0;
    logic [RW-1:0] s_data = '0;
    logic [RW-1:0] data_from_out_mat;
    logic busy, job_done, s_ready, m_valid, enable_writing_to_mem, enable_reading_from_mem;
    logic we_a, we_b, we_c, start_mat_mul;
    logic [AW-1:0] addr_pi;
    logic [RW-1:0] data_pi, m_data;

    int passed = 0, total = 0;

    typedef struct { int k; int cyc; } wr_t;
    wr_t wq[$];
    logic [RW-1:0] rq[$];

    always #5 clk = ~clk;

    matmul_host_ctrl #(.DWIDTH(DW), .AWIDTH(AW), .MAT_MUL_SIZE(MS), .NUM_ROWS(NR),
                       .RD_LAT(RL), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .reset(reset), .go(go), .busy(busy), .job_done(job_done),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .enable_writing_to_mem(enable_writing_to_mem),
        .enable_reading_from_mem(enable_reading_from_mem),
        .addr_pi(addr_pi), .data_pi(data_pi), .we_a(we_a), .we_b(we_b), .we_c(we_c),
        .start_mat_mul(start_mat_mul), .done_mat_mul(done_mat_mul),
        .data_from_out_mat(data_from_out_mat)
    );

    function automatic logic [RW-1:0] row_pat(input int k);
        logic [RW-1:0] r;
        for (int e = 0; e < MS; e++) r[e*DW +: DW] = DW'(k * 256 + e);
        return r;
    endfunction

    function automatic logic [RW-1:0] c_row(input logic [AW-1:0] a);
        logic [RW-1:0] r;
        for (int e = 0; e < MS; e++) r[e*DW +: DW] = DW'(49152 + 37 * int'(a) + e);
        return r;
    endfunction

    // Accelerator C memory: read data appears RL cycles after the address.
    logic [AW-1:0] ah [RL];
    always @(posedge clk) begin
        ah[0] <= addr_pi;
        for (int i = 1; i < RL; i++) ah[i] <= ah[i-1];
    end
    assign data_from_out_mat = c_row(ah[RL-1]);

    function automatic logic [10+AW+2*RW-1:0] outs_vec();
        return {busy, job_done, s_ready, m_valid, enable_writing_to_mem, enable_reading_from_mem,
                we_a, we_b, we_c, start_mat_mul, addr_pi, data_pi, m_data};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; s_valid = 1'b0; go = 1'b0; done_mat_mul = 1'b0;
        step();
        reset = 1'b0;
    endtask

    // Drives a complete load and run phase; returns in the first READ cycle.
    task automatic run_to_read();
        go = 1'b1; step(); go = 1'b0;
        for (int k = 0; k < 2 * NR; k++) begin
            s_valid = 1'b1; s_data = row_pat(k);
            step();
        end
        s_valid = 1'b0;
        step(); step();
        done_mat_mul = 1'b1; step(); done_mat_mul = 1'b0;
    endtask

    task automatic test_reset();
        step();
        @(negedge clk);
        total++;
        if (outs_vec() !== '0) $display("FAIL reset_outputs: got %h expected 0", outs_vec());
        else passed++;
        reset = 1'b0;
        step();
        @(negedge clk);
        total++;
        if (outs_vec() !== '0) $display("FAIL idle_after_reset: got %h expected 0", outs_vec());
        else passed++;
    endtask

    task automatic test_ignore();
        done_mat_mul = 1'b1;
        step(); done_mat_mul = 1'b0;
        @(negedge clk);
        total++;
        if ({busy, start_mat_mul, s_ready} !== 3'b000)
            $display("FAIL done_in_idle: got %b expected 000", {busy, start_mat_mul, s_ready});
        else passed++;
        go = 1'b1; step(); go = 1'b0;
        @(negedge clk);
        total++;
        if ({busy, s_ready} !== 2'b11) $display("FAIL go_accept: got %b expected 11", {busy, s_ready});
        else passed++;
        step(); go = 1'b1; done_mat_mul = 1'b1;
        step(); go = 1'b0; done_mat_mul = 1'b0;
        @(negedge clk);
        total++;
        if ({busy, s_ready, start_mat_mul, we_c} !== 4'b1100)
            $display("FAIL ignore_in_load: got %b expected 1100", {busy, s_ready, start_mat_mul, we_c});
        else passed++;
        step(); s_valid = 1'b1; s_data = row_pat(5);
        @(negedge clk);
        total++;
        if (addr_pi !== 7'd0) $display("FAIL row_idx_kept: got %0d expected 0", addr_pi);
        else passed++;
        step(); s_valid = 1'b0;
        do_reset();
    endtask

    task automatic test_stall();
        int k = 0, nw = 0;
        bit fin = 1'b0;
        wr_t h;
        wq.delete();
        go = 1'b1; step(); go = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            s_valid = (k < 10) && !(cyc >= 4 && cyc < 9);
            s_data = row_pat(k);
            @(negedge clk);
            if (s_valid && s_ready) begin
                total++;
                if (addr_pi !== AW'(k)) $display("FAIL stall_addr: got %0d expected %0d", addr_pi, k);
                else passed++;
                wq.push_back('{k, cyc});
                k++;
            end
            if (we_a || we_b) begin
                total++;
                if (wq.size() == 0) $display("FAIL stall_spurious_write: got write at cycle %0d expected none", cyc);
                else begin
                    h = wq.pop_front();
                    nw++;
                    if (cyc != h.cyc + 2 || we_a !== 1'b1 || data_pi !== row_pat(h.k))
                        $display("FAIL stall_write: got cycle %0d we_a %b data %h expected cycle %0d we_a 1 data %h",
                                 cyc, we_a, data_pi, h.cyc + 2, row_pat(h.k));
                    else passed++;
                end
            end
            if (k == 10 && wq.size() == 0) begin fin = 1'b1; break; end
            step();
        end
        total++;
        if (!fin || nw != 10) $display("FAIL stall_count: got %0d writes expected 10", nw);
        else passed++;
        s_valid = 1'b0;
        do_reset();
    endtask

    task automatic test_reset_midjob();
        go = 1'b1; step(); go = 1'b0;
        for (int k = 0; k < NR + 4; k++) begin
            s_valid = 1'b1; s_data = row_pat(k);
            step();
        end
        reset = 1'b1;
        step();
        @(negedge clk);
        total++;
        if (outs_vec() !== '0) $display("FAIL reset_mid_load: got %h expected 0", outs_vec());
        else passed++;
        reset = 1'b0; s_valid = 1'b0;
        step();
        @(negedge clk);
        total++;
        if (outs_vec() !== '0) $display("FAIL write_after_reset: got %h expected 0", outs_vec());
        else passed++;
        step();
        m_ready = 1'b0;
        run_to_read();
        step(); step();
        reset = 1'b1;
        step();
        @(negedge clk);
        total++;
        if (outs_vec() !== '0) $display("FAIL reset_mid_read: got %h expected 0", outs_vec());
        else passed++;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) step();
        @(negedge clk);
        total++;
        if ({m_valid, busy} !== 2'b00) $display("FAIL discard_inflight: got %b expected 00", {m_valid, busy});
        else passed++;
        step();
    endtask

    task automatic test_load();
        int k = 0, na = 0, nb = 0;
        bit fin = 1'b0;
        wr_t h;
        wq.delete();
        m_ready = 1'b0;
        go = 1'b1; step(); go = 1'b0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            s_valid = (k < 2 * NR);
            s_data = row_pat(k);
            @(negedge clk);
            if (s_valid && s_ready) begin
                total++;
                if (addr_pi !== AW'(k % NR)) $display("FAIL load_addr: got %0d expected %0d", addr_pi, k % NR);
                else passed++;
                wq.push_back('{k, cyc});
                k++;
            end
            if (we_a || we_b) begin
                total++;
                if (wq.size() == 0) $display("FAIL load_spurious_write: got write at cycle %0d expected none", cyc);
                else begin
                    h = wq.pop_front();
                    if (we_a) na++;
                    if (we_b) nb++;
                    if (cyc != h.cyc + 2 || we_a !== (h.k < NR) || we_b !== (h.k >= NR) || data_pi !== row_pat(h.k))
                        $display("FAIL load_write: got cycle %0d we %b%b data %h expected cycle %0d row %0d data %h",
                                 cyc, we_a, we_b, data_pi, h.cyc + 2, h.k, row_pat(h.k));
                    else passed++;
                end
            end
            if (k == 2 * NR && wq.size() == 0) begin fin = 1'b1; break; end
            step();
        end
        s_valid = 1'b0;
        total++;
        if (!fin || na != NR || nb != NR) $display("FAIL load_counts: got we_a %0d we_b %0d expected 16 16", na, nb);
        else passed++;
        total++;
        if ({s_ready, enable_writing_to_mem, start_mat_mul} !== 3'b010)
            $display("FAIL flush_outputs: got %b expected 010", {s_ready, enable_writing_to_mem, start_mat_mul});
        else passed++;
    endtask

    task automatic test_run();
        int hi = 0;
        for (int r = 1; r <= 40; r++) begin
            step();
            done_mat_mul = (r == 40);
            @(negedge clk);
            if (start_mat_mul && we_c) hi++;
        end
        step(); done_mat_mul = 1'b0;
        @(negedge clk);
        total++;
        if (hi != 40) $display("FAIL run_len: got %0d cycles expected 40", hi);
        else passed++;
        total++;
        if ({start_mat_mul, we_c, enable_reading_from_mem} !== 3'b001)
            $display("FAIL run_stop: got %b expected 001", {start_mat_mul, we_c, enable_reading_from_mem});
        else passed++;
    endtask

    task automatic test_backpressure();
        int issued = 0, popped = 0, jd = 0, post = 0, maxo = 0;
        logic [RW-1:0] exp;
        rq.delete();
        for (int i = 0; i < NR; i++) rq.push_back(c_row(AW'(i)));
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (cyc > 0) begin
                step();
                m_ready = (cyc >= 12);
                @(negedge clk);
            end
            if (enable_reading_from_mem && issued < NR &&
                ((issued == 0) ? (cyc == 0) : (addr_pi == AW'(issued))))
                issued++;
            if (issued - popped > maxo) maxo = issued - popped;
            if (cyc == 11) begin
                total++;
                if (issued != FD || m_valid !== 1'b1)
                    $display("FAIL bp_hold: got issued %0d m_valid %b expected %0d 1", issued, m_valid, FD);
                else passed++;
            end
            if (m_valid && m_ready) begin
                total++;
                if (rq.size() == 0) $display("FAIL bp_extra_row: got %h expected none", m_data);
                else begin
                    exp = rq.pop_front();
                    if (m_data !== exp) $display("FAIL bp_row%0d: got %h expected %h", popped, m_data, exp);
                    else passed++;
                end
                popped++;
            end
            if (job_done) jd++;
            if (jd > 0) post++;
            if (post >= 4) break;
        end
        m_ready = 1'b0;
        total++;
        if (popped != NR || rq.size() != 0) $display("FAIL bp_all_rows: got %0d rows expected %0d", popped, NR);
        else passed++;
        total++;
        if (jd != 1) $display("FAIL bp_job_done: got %0d pulses expected 1", jd);
        else passed++;
        total++;
        if (maxo > FD) $display("FAIL bp_outstanding: got %0d expected <= %0d", maxo, FD);
        else passed++;
        total++;
        if (busy !== 1'b0) $display("FAIL bp_busy_clear: got %b expected 0", busy);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int popped = 0, jd = 0, post = 0;
        logic [RW-1:0] exp;
        rq.delete();
        m_ready = 1'b1;
        run_to_read();
        for (int i = 0; i < NR; i++) rq.push_back(c_row(AW'(i)));
        for (int cyc = 0; cyc < 150; cyc++) begin
            @(negedge clk);
            if (m_valid && m_ready) begin
                total++;
                if (rq.size() == 0) $display("FAIL b2b_extra_row: got %h expected none", m_data);
                else begin
                    exp = rq.pop_front();
                    if (m_data !== exp) $display("FAIL b2b_row%0d: got %h expected %h", popped, m_data, exp);
                    else passed++;
                end
                popped++;
            end
            if (job_done) jd++;
            if (jd > 0) post++;
            if (post >= 4) break;
            step();
        end
        m_ready = 1'b0;
        total++;
        if (popped != NR || jd != 1) $display("FAIL b2b_job: got rows %0d job_done %0d expected 16 1", popped, jd);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_ignore();
        test_stall();
        test_reset_midjob();
        test_load();
        test_run();
        test_backpressure();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
